// File: rtl/fetch_queue.sv
// fetch_queue: in-order {PC, instr} prefetch buffer between fetch and decode, flushable on redirect.
// Define FETCH_QUEUE_BYPASS_EN for zero-cycle pass-through when the queue is empty.
module fetch_queue #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int DEPTH         = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [ADDRESS_WIDTH-1:0] in_pc,
  input  logic [DATA_WIDTH-1:0]    in_instr,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [ADDRESS_WIDTH-1:0] out_pc,
  output logic [DATA_WIDTH-1:0]    out_instr,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int IW = $clog2(DEPTH);
  localparam int PW = IW + 1;

  logic [PW-1:0]            wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]            rd_ptr_q, rd_ptr_d;
  logic [ADDRESS_WIDTH-1:0] pc_mem_q    [DEPTH];
  logic [DATA_WIDTH-1:0]    instr_mem_q [DEPTH];
  logic                     empty, full, push, pop, bypass, byp_take;

  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign full     = (wr_ptr_q[IW-1:0] == rd_ptr_q[IW-1:0]) && (wr_ptr_q[IW] != rd_ptr_q[IW]);
  assign count    = wr_ptr_q - rd_ptr_q;
  // Slot freed by a pop is not reusable until the next cycle: in_ready depends on state only.
  assign in_ready = !full;

`ifdef FETCH_QUEUE_BYPASS_EN
  assign bypass = empty && in_valid && !flush;
`else
  assign bypass = 1'b0;
`endif

  assign byp_take  = bypass && out_ready;
  assign push      = in_valid && in_ready && !byp_take;
  assign pop       = !empty && out_ready;
  assign out_valid = !empty || bypass;

  always_comb begin
    out_pc    = '0;
    out_instr = '0;
    if (!empty) begin
      out_pc    = pc_mem_q[rd_ptr_q[IW-1:0]];
      out_instr = instr_mem_q[rd_ptr_q[IW-1:0]];
    end
`ifdef FETCH_QUEUE_BYPASS_EN
    else if (bypass) begin
      out_pc    = in_pc;
      out_instr = in_instr;
    end
`endif
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset: outputs are gated by empty.
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      pc_mem_q[wr_ptr_q[IW-1:0]]    <= in_pc;
      instr_mem_q[wr_ptr_q[IW-1:0]] <= in_instr;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Testbench for fetch_queue: directed scenarios plus random traffic against a queue-based model.
module tb_fetch_queue;
  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;
  localparam int VW    = 2 + CW + AW + DW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b0;
  logic [AW-1:0] in_pc = '0;
  logic [DW-1:0] in_instr = '0;
  logic          in_ready, out_valid;
  logic [AW-1:0] out_pc;
  logic [DW-1:0] out_instr;
  logic [CW-1:0] count;

  always #5 clk = ~clk;

  fetch_queue #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_instr(in_instr),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_instr(out_instr),
    .count(count)
  );

  // Observed and expected: {out_valid, in_ready, count, out_pc, out_instr}
  logic [VW-1:0]       obs;
  logic [VW-1:0]       exp_vec;
  logic [VW-1:0]       rst_vec;
  logic [AW+DW-1:0]    mq[$];
  logic                byp;
  int                  n_cmp = 0;
  int                  n_bad = 0;

  assign obs     = {out_valid, in_ready, count, out_pc, out_instr};
  assign rst_vec = {1'b0, 1'b1, {CW{1'b0}}, {AW{1'b0}}, {DW{1'b0}}};

  function automatic logic [DW-1:0] instr_of(input logic [AW-1:0] pc);
    return ~pc ^ 32'h1357_9BDF;
  endfunction

  // Apply inputs just after an edge and form the expected outputs from the model.
  task automatic drive(input logic iv, input logic [AW-1:0] pc, input logic ordy, input logic fl);
    logic [AW+DW-1:0] head;
    in_valid = iv; in_pc = pc; in_instr = instr_of(pc); out_ready = ordy; flush = fl;
    byp = 1'b0;
`ifdef FETCH_QUEUE_BYPASS_EN
    byp = (mq.size() == 0) && iv && !fl;
`endif
    head = '0;
    if (mq.size() > 0) head = mq[0];
    else if (byp) head = {pc, instr_of(pc)};
    exp_vec = {(mq.size() > 0) || byp, mq.size() < DEPTH, CW'(mq.size()), head};
    #2;
  endtask

  task automatic advance();
    logic pop_m, push_m;
    @(posedge clk);
    if (flush) mq.delete();
    else begin
      pop_m  = (mq.size() > 0) && out_ready;
      push_m = in_valid && (mq.size() < DEPTH) && !(byp && out_ready);
      if (pop_m)  void'(mq.pop_front());
      if (push_m) mq.push_back({in_pc, in_instr});
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #3;
    n_cmp++;
    if (obs !== rst_vec) begin n_bad++; $display("FAIL reset_held got %h want %h", obs, rst_vec); end
    rst = 1'b0;
    #1;
    n_cmp++;
    if (obs !== rst_vec) begin n_bad++; $display("FAIL reset_released got %h want %h", obs, rst_vec); end
    mq.delete();
    @(posedge clk); #1;
  endtask

  task automatic test_fill_full();
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, AW'(4 * i), 1'b0, 1'b0);
      n_cmp++;
      if (obs !== exp_vec) begin n_bad++; $display("FAIL fill[%0d] got %h want %h", i, obs, exp_vec); end
      advance();
    end
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, '0, 1'b1, 1'b0);
      n_cmp++;
      if (obs !== exp_vec) begin n_bad++; $display("FAIL drain[%0d] got %h want %h", i, obs, exp_vec); end
      advance();
    end
  endtask

  task automatic test_concurrent();
    logic [AW-1:0] pcs [3];
    logic          rdy [3];
    pcs = '{32'h18, 32'h1C, 32'h20};
    rdy = '{1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, pcs[i], rdy[i], 1'b0);
      n_cmp++;
      if (obs !== exp_vec) begin n_bad++; $display("FAIL concur[%0d] got %h want %h", i, obs, exp_vec); end
      advance();
    end
    n_cmp++;
    if (count !== CW'(2)) begin n_bad++; $display("FAIL concur_count got %0d want 2", count); end
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, '0, 1'b1, 1'b0);
      n_cmp++;
      if (obs !== exp_vec) begin n_bad++; $display("FAIL concur_drain[%0d] got %h want %h", i, obs, exp_vec); end
      advance();
    end
  endtask

  task automatic test_flush();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, AW'(32'h30 + 4 * i), 1'b0, 1'b0);
      advance();
    end
    drive(1'b1, 32'h40, 1'b0, 1'b1);
    n_cmp++;
    if (obs !== exp_vec) begin n_bad++; $display("FAIL flush_cycle got %h want %h", obs, exp_vec); end
    advance();
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, '0, 1'b1, 1'b0);
      n_cmp++;
      if (obs !== exp_vec) begin n_bad++; $display("FAIL after_flush[%0d] got %h want %h", i, obs, exp_vec); end
      n_cmp++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        n_bad++; $display("FAIL flush_empty[%0d] got valid=%b ready=%b want 0 1", i, out_valid, in_ready);
      end
      advance();
    end
  endtask

  task automatic test_wrap();
    int k = 0;
    int got_n = 0;
    for (int cyc = 0; cyc < 80 && (k < 10 || mq.size() > 0); cyc++) begin
      logic acc;
      drive(k < 10, AW'(32'h100 + 4 * k), cyc[0], 1'b0);
      acc = (k < 10) && (mq.size() < DEPTH);
      n_cmp++;
      if (obs !== exp_vec) begin n_bad++; $display("FAIL wrap[%0d] got %h want %h", cyc, obs, exp_vec); end
      n_cmp++;
      if (count > CW'(DEPTH)) begin n_bad++; $display("FAIL wrap_count[%0d] got %0d want <= %0d", cyc, count, DEPTH); end
      if (out_valid === 1'b1 && out_ready) begin
        n_cmp++;
        if (out_pc !== AW'(32'h100 + 4 * got_n)) begin
          n_bad++; $display("FAIL wrap_order[%0d] got %h want %h", got_n, out_pc, 32'h100 + 4 * got_n);
        end
        got_n++;
      end
      advance();
      if (acc) k++;
    end
    n_cmp++;
    if (got_n != 10) begin n_bad++; $display("FAIL wrap_total got %0d want 10", got_n); end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, AW'(32'h50 + 4 * i), 1'b0, 1'b0);
      advance();
    end
    drive(1'b0, '0, 1'b0, 1'b0);
    n_cmp++;
    if (obs !== exp_vec) begin n_bad++; $display("FAIL pre_areset got %h want %h", obs, exp_vec); end
    rst = 1'b1;
    #1;
    n_cmp++;
    if (obs !== rst_vec) begin n_bad++; $display("FAIL mid_areset got %h want %h", obs, rst_vec); end
    rst = 1'b0;
    mq.delete();
    @(posedge clk); #1;
    drive(1'b0, '0, 1'b1, 1'b0);
    n_cmp++;
    if (obs !== exp_vec) begin n_bad++; $display("FAIL post_areset got %h want %h", obs, exp_vec); end
    advance();
  endtask

`ifdef FETCH_QUEUE_BYPASS_EN
  task automatic test_bypass();
    drive(1'b1, 32'h200, 1'b1, 1'b0);
    n_cmp++;
    if (out_valid !== 1'b1 || out_pc !== 32'h200) begin
      n_bad++; $display("FAIL bypass got valid=%b pc=%h want 1 00000200", out_valid, out_pc);
    end
    advance();
    n_cmp++;
    if (count !== '0 || out_valid !== 1'b0) begin
      n_bad++; $display("FAIL bypass_after got count=%0d valid=%b want 0 0", count, out_valid);
    end
  endtask
`endif

  task automatic test_random();
    for (int cyc = 0; cyc < 400; cyc++) begin
      drive(($urandom % 4) != 0, $urandom & 32'hFFFF_FFFC, ($urandom % 3) != 0, ($urandom % 23) == 0);
      n_cmp++;
      if (obs !== exp_vec) begin n_bad++; $display("FAIL random[%0d] got %h want %h", cyc, obs, exp_vec); end
      advance();
    end
  endtask

  initial begin
    test_reset();
    test_fill_full();
    test_concurrent();
    test_flush();
    test_wrap();
    test_async_reset();
`ifdef FETCH_QUEUE_BYPASS_EN
    test_bypass();
`endif
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
Instruction prefetch buffer between the fetch stage (PC register + instruction ROM) and decode. Fetch pushes {PC, instr} pairs with a valid/ready handshake. Decode pops them in program order with a valid/ready handshake. A flush input discards all buffered entries on a taken branch/jump (PCsrc redirect), so wrong-path instructions never reach decode.

Parameters:
ADDRESS_WIDTH, 32, width of stored PC
DATA_WIDTH, 32, width of stored instruction word
DEPTH, 4, number of entries; power of two, >= 2

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  reset; asynchronous, active-high
flush  input  1  synchronous discard of all entries
in_valid  input  1  fetch presents a valid entry
in_ready  output  1  queue can accept an entry this cycle
in_pc  input  ADDRESS_WIDTH  PC of the fetched instruction
in_instr  input  DATA_WIDTH  fetched instruction word
out_valid  output  1  head entry valid for decode
out_ready  input  1  decode consumes head this cycle
out_pc  output  ADDRESS_WIDTH  PC of head entry
out_instr  output  DATA_WIDTH  instruction of head entry
count  output  $clog2(DEPTH)+1  number of occupied entries

Behaviour:
- Storage: circular buffer of DEPTH entries. Write pointer and read pointer are each $clog2(DEPTH)+1 bits; the MSB is the wrap bit.
- empty = (wr_ptr == rd_ptr). full = index bits equal and wrap bits differ.
- count = wr_ptr - rd_ptr, modulo 2^($clog2(DEPTH)+1).
- Reset (async, rst=1): both pointers = 0, count = 0. Outputs: out_valid = 0, in_ready = 1, out_pc = 0, out_instr = 0. Storage contents are don't-care.
- A reset asserted mid-operation immediately drops out_valid and discards all entries.
- in_ready = !full, combinational from registered state only. It does not depend on out_ready, so a pop does not free a slot for a push in the same cycle when full.
- push = in_valid && in_ready. On a push, the entry is written at wr_ptr and wr_ptr increments.
- pop = out_valid && out_ready. On a pop, rd_ptr increments.
- out_valid = !empty.
- out_pc/out_instr come from the entry at rd_ptr while out_valid = 1. They are forced to 0 while empty.
- Latency: an entry pushed at edge N is visible on the outputs after edge N (out_valid high in cycle N+1).
- Simultaneous push and pop (0 < count < DEPTH): both occur and count is unchanged.
- Full (count = DEPTH): in_ready = 0, and in_valid is ignored.
- Empty (count = 0): out_ready is ignored and the pointers do not move.
- Wrap-around: pointers increment modulo 2^($clog2(DEPTH)+1). Ordering is preserved across wrap.
- flush (synchronous, highest priority): at the next edge both pointers = 0 and count = 0.
  - A push in the same cycle is discarded.
  - A pop in the same cycle has no further effect.
  - in_ready = 1 in the following cycle.
- Handshake rule: once out_valid = 1, out_pc/out_instr stay stable until a pop, flush or reset.
- No X propagation on outputs after reset.

Optional Feature:
Macro FETCH_QUEUE_BYPASS_EN.
- Defined: when the queue is empty and in_valid = 1 (no flush), out_valid = 1 in the same cycle and out_pc/out_instr = in_pc/in_instr combinationally.
  - If out_ready is also 1, the entry is consumed directly: nothing is written and the pointers are unchanged.
  - If out_ready = 0, the entry is written normally.
  - This gives zero-cycle latency through an empty queue.
- Not defined: the queue has a strict one-cycle latency and no combinational path from in_* to out_*.

Test Plan:
- Reset/idle: rst=1, then deassert -> out_valid=0, in_ready=1, count=0, out_pc=0, out_instr=0.
- Fill/full: with out_ready=0, push PCs 0x0, 0x4, 0x8, 0xC, then present 0x10 -> count=4, in_ready=0, 0x10 not accepted. Then out_ready=1 -> outputs 0x0, 0x4, 0x8, 0xC in order, then count=0.
- Concurrent push/pop at count=2: one cycle with push 0x20 and pop -> count stays 2, head advances, 0x20 emerges after the older entries.
- Flush: with count=3, assert flush together with in_valid (PC 0x40) -> next cycle count=0, out_valid=0, 0x40 never appears on out_pc.
- Wrap/ordering: stream 10 entries (PCs 0x100 + 4k) with out_ready toggling every cycle -> all 10 emerge in order and count never exceeds 4.
- Async reset mid-stream: at count=2, pulse rst between edges -> out_valid drops before the next edge, count=0. With FETCH_QUEUE_BYPASS_EN defined, an empty queue with in_valid=1 and out_ready=1 (PC 0x200) shows out_pc=0x200 in the same cycle and count stays 0.
